// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the memory port.
// The arbiter connects through the slave modport; masters and memory use master.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_we;
  logic              m1_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic              m0_err;
  logic              m1_err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_ack, m1_ack, m0_err, m1_err, rdata,
    output mem_address, mem_wdata, mem_read, mem_write
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_ack, m1_ack, m0_err, m1_err, rdata,
    input  mem_address, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the single memory bus.
// Optional wait-state timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input logic             clock,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit wait counter (1..255)");
  end

  state_t            r_state;
  // Doubles as the current grantee once a transaction is under way.
  logic              r_last_grant;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
`ifdef ARB_TIMEOUT_EN
  logic              r_m0_err;
  logic              r_m1_err;
  logic [7:0]        r_cnt;
`endif

  logic              w_any;
  logic              w_pick;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_any   = bus.m0_req | bus.m1_req;
    // M1 wins when alone, or on a tie when M0 was served last.
    w_pick  = bus.m1_req & (~bus.m0_req | ~r_last_grant);
    w_we    = w_pick ? bus.m1_we    : bus.m0_we;
    w_addr  = w_pick ? bus.m1_addr  : bus.m0_addr;
    w_wdata = w_pick ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_m0_ack      <= 1'b0;
      r_m1_ack      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rdata       <= '0;
`ifdef ARB_TIMEOUT_EN
      r_m0_err      <= 1'b0;
      r_m1_err      <= 1'b0;
      r_cnt         <= 8'd0;
`endif
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last_grant  <= w_pick;
            r_mem_address <= w_addr;
            r_mem_wdata   <= w_wdata;
            r_mem_read    <= ~w_we;
            r_mem_write   <= w_we;
`ifdef ARB_TIMEOUT_EN
            r_cnt         <= 8'd0;
`endif
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (r_mem_read) r_rdata <= bus.mem_rdata;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_m0_ack    <= ~r_last_grant;
            r_m1_ack    <= r_last_grant;
            r_state     <= DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_rdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_m0_ack    <= ~r_last_grant;
            r_m1_ack    <= r_last_grant;
            r_m0_err    <= ~r_last_grant;
            r_m1_err    <= r_last_grant;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack      = r_m0_ack;
  assign bus.m1_ack      = r_m1_ack;
  assign bus.rdata       = r_rdata;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
`ifdef ARB_TIMEOUT_EN
  assign bus.m0_err      = r_m0_err;
  assign bus.m1_err      = r_m1_err;
`else
  assign bus.m0_err      = 1'b0;
  assign bus.m1_err      = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and sequencer for the processor's single 64-bit memory bus. It shares the memory port between the processor data path (master 0) and a program/data loader or DMA engine (master 1). Each transaction is granted round-robin, the memory strobes and address are driven from registers, memory wait states are absorbed, and a one-cycle acknowledge with read data is returned. It sits between `Processor` and the memory model at the system top level.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width.
- `TIMEOUT`, 16: wait-state limit in cycles. Used only with `ARB_TIMEOUT_EN`.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  transaction request, level; held until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req high.
- `m0_addr`, `m1_addr`  in  ADDR_W  address; stable while req high.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; stable while req high.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  timeout abort flag, coincident with ack.
- `rdata`  out  DATA_W  read data, shared; valid only in an ack cycle of a read.
- `mem_address`  out  ADDR_W  registered address to memory.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_read`, `mem_write`  out  1  registered strobes, mutually exclusive.
- `mem_rdata`  in  DATA_W  memory read data.
- `mem_ready`  in  1  memory completes the access this cycle.

## Operation
- FSM states: IDLE, BUSY, DONE (2-bit encoding; IDLE = 0).
- IDLE:
  - If no req, stay.
  - If exactly one req, grant that master.
  - If both req, grant the master that is not `last_grant`; then `last_grant` ← grantee.
  - On grant: latch addr, wdata, and we into the `mem_*` registers, assert `mem_read` or `mem_write`, go BUSY.
- BUSY:
  - Strobes and address are held.
  - If `mem_ready` is sampled high: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), drop strobes, go DONE.
- DONE:
  - Assert the grantee's ack for exactly this cycle. Requests are not evaluated here.
  - Go IDLE.
- Masters must deassert req at the edge ending their ack cycle unless they issue a new transaction. A req still high in IDLE is a new transaction.
- A master's inputs changing while its req is high and it is not yet granted is harmless; values are latched at grant.
- The non-granted master waits with req high. No starvation: after any grant, a contending master wins the next tie.

## Timing
- Reset values (async, immediate): state IDLE, `last_grant` = 1 (so M0 wins the first tie), all acks/errs/strobes 0, `mem_address`/`mem_wdata`/`rdata` 0, timeout counter 0.
- Latency, zero wait states:
  - req high before edge 1.
  - Strobes high cycle 1; `mem_ready` sampled at edge 2.
  - Ack high cycle 2; IDLE cycle 3.
  - Minimum 3 cycles per transaction. Back-to-back grants every 3 cycles.
- Each memory wait state (`mem_ready` low in BUSY) adds 1 cycle.
- `mem_ready` outside BUSY is ignored.
- Reset asserted mid-transaction: strobes drop asynchronously, no ack or err is issued, and the aborted transaction is lost. Masters must re-request.
- `rdata` holds its last captured value outside ack cycles.

## Configuration
- `ARB_TIMEOUT_EN` defined: an 8-bit counter clears on entering BUSY and increments each BUSY cycle with `mem_ready` low. When the counter reaches `TIMEOUT` with `mem_ready` still low:
  - drop strobes and go DONE;
  - in the DONE cycle, the grantee's ack and err are both high, and `rdata` is forced to 0.
- `ARB_TIMEOUT_EN` undefined: BUSY waits indefinitely, the counter is absent, and `m0_err`/`m1_err` are tied 0.

## Test plan
- Reset then single read: `m0_req`=1, `m0_we`=0, `m0_addr`=0x40, `mem_ready` tied 1, `mem_rdata`=0xDEAD → `mem_read` high cycle 1 with `mem_address`=0x40; `m0_ack`=1 and `rdata`=0xDEAD in cycle 2; back to IDLE in cycle 3.
- Simultaneous requests, both held continuously → grants M0, M1, M0, M1 in order, acks in cycles 2, 5, 8, 11.
- Write with 3 wait states: `m1_we`=1, addr 0x100, wdata 0x1234, `mem_ready` low 3 cycles → `mem_write` high 4 cycles, `m1_ack` in cycle 5, `rdata` unchanged.
- Async reset asserted in BUSY with a read pending → `mem_read`=0 immediately, no ack; after release, M0 wins a tie.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=16, `mem_ready` stuck 0 → strobe high 16 cycles, then `m0_ack`=`m0_err`=1 with `rdata`=0. Without the macro, no ack ever appears and err stays 0.
- Stray `mem_ready` pulses in IDLE and DONE → no state change and no extra acks.
